// File: rtl/alu_pkg.sv
// Shared opcodes, header constants and FSM state encoding for the ALU packet responder.
package alu_pkg;

    localparam int unsigned HEADER_LEN = 4;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD32 = 8'hA0;
    localparam logic [7:0] OP_MUL32 = 8'hB0;

    typedef enum logic [2:0] {
        OPC,
        RSVD,
        LENLO,
        LENHI,
        ECHO,
        ACC,
        RESP,
        DRAIN
    } state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Shifts bytes LSB-first into an operand word; word_c/word_valid_c present the
// completed word in the same cycle the final byte is accepted.
module byte_word_assembler #(
    parameter int unsigned DATA_WIDTH_P    = 8,
    parameter int unsigned OPERAND_WIDTH_P = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       byte_valid,
    input  logic [DATA_WIDTH_P-1:0]    byte_data,
    output logic [OPERAND_WIDTH_P-1:0] word_c,
    output logic                       word_valid_c
);

    localparam int unsigned WORD_BYTES = OPERAND_WIDTH_P / DATA_WIDTH_P;
    localparam int unsigned CNT_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned SHIFT_W    = OPERAND_WIDTH_P - DATA_WIDTH_P;

    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   count_q;

    // Newest byte lands in the top lane; after WORD_BYTES bytes the first is the LSB.
    assign word_c       = {byte_data, shift_q};
    assign word_valid_c = byte_valid && (count_q == CNT_W'(WORD_BYTES - 1));

    // Partial-word storage and byte position, cleared at each packet start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (byte_valid) begin
            shift_q <= word_c[OPERAND_WIDTH_P-1:DATA_WIDTH_P];
            count_q <= word_valid_c ? '0 : count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_packet_responder.sv
// Packet command engine between the UART rx and tx streams: echo, 32-bit add,
// and (with ALU_MUL32_EN defined) 32-bit multiply. Without ALU_MUL32_EN the
// multiply opcode is treated as unknown and no multiplier is built.
module alu_packet_responder
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P    = 8,
    parameter int unsigned OPERAND_WIDTH_P = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
    input  logic                    rx_tvalid_i,
    output logic                    rx_tready_o,
    output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
    output logic                    tx_tvalid_o,
    input  logic                    tx_tready_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int unsigned WORD_BYTES = OPERAND_WIDTH_P / DATA_WIDTH_P;
    localparam int unsigned IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned LEN_W      = 2 * DATA_WIDTH_P;

`ifdef ALU_MUL32_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t                     state_q, state_d;
    logic [DATA_WIDTH_P-1:0]    opcode_q, opcode_d;
    logic [DATA_WIDTH_P-1:0]    len_lo_q, len_lo_d;
    logic [LEN_W-1:0]           remaining_q, remaining_d;
    logic [OPERAND_WIDTH_P-1:0] acc_q, acc_d;
    logic [DATA_WIDTH_P-1:0]    tx_data_q, tx_data_d;
    logic                       tx_valid_q, tx_valid_d;
    logic                       err_q, err_d;
    logic [IDX_W-1:0]           idx_q, idx_d;

    logic                       rx_fire_c;
    logic                       tx_fire_c;
    logic [LEN_W-1:0]           len_full_c;
    logic [LEN_W-1:0]           payload_c;
    logic                       arith_op_c;
    logic                       arith_len_ok_c;
    logic                       last_byte_c;
    logic                       asm_clear_c;
    logic                       asm_valid_c;
    logic [OPERAND_WIDTH_P-1:0] word_c;
    logic                       word_valid_c;
    logic [OPERAND_WIDTH_P-1:0] result_c;

    assign tx_tdata_o  = tx_data_q;
    assign tx_tvalid_o = tx_valid_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != OPC);

    assign rx_fire_c      = rx_tvalid_i && rx_tready_o;
    assign tx_fire_c      = tx_valid_q && tx_tready_i;
    assign len_full_c     = {rx_tdata_i, len_lo_q};
    assign payload_c      = len_full_c - LEN_W'(HEADER_LEN);
    assign arith_op_c     = (opcode_q == OP_ADD32) || (MUL_EN && (opcode_q == OP_MUL32));
    assign arith_len_ok_c = (payload_c != '0) && ((payload_c % LEN_W'(WORD_BYTES)) == '0);
    assign last_byte_c    = (remaining_q == LEN_W'(1));
    assign asm_valid_c    = rx_fire_c && (state_q == ACC);

    // Operand word assembly for ADD/MUL payloads.
    byte_word_assembler #(
        .DATA_WIDTH_P   (DATA_WIDTH_P),
        .OPERAND_WIDTH_P(OPERAND_WIDTH_P)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear       (asm_clear_c),
        .byte_valid  (asm_valid_c),
        .byte_data   (rx_tdata_i),
        .word_c      (word_c),
        .word_valid_c(word_valid_c)
    );

`ifdef ALU_MUL32_EN
    // Accumulator update: low word of the product or modular sum.
    assign result_c = (opcode_q == OP_MUL32) ? OPERAND_WIDTH_P'(acc_q * word_c)
                                             : OPERAND_WIDTH_P'(acc_q + word_c);
`else
    // Accumulator update: modular sum only.
    assign result_c = OPERAND_WIDTH_P'(acc_q + word_c);
`endif

    // rx ready is a decode of the current state, forced low while in reset.
    always_comb begin
        rx_tready_o = 1'b0;
        if (!rst) begin
            case (state_q)
                ECHO:    rx_tready_o = !tx_valid_q || tx_tready_i;
                RESP:    rx_tready_o = 1'b0;
                default: rx_tready_o = 1'b1;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OPC;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            remaining_q <= '0;
            acc_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
        end
    end

    // Next-state and datapath decode; a pending tx byte retires on its handshake in any state.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q && !tx_tready_i;
        err_d       = 1'b0;
        idx_d       = idx_q;
        asm_clear_c = 1'b0;

        case (state_q)
            OPC: begin
                if (rx_fire_c) begin
                    opcode_d = rx_tdata_i;
                    state_d  = RSVD;
                end
            end
            RSVD: begin
                if (rx_fire_c) state_d = LENLO;
            end
            LENLO: begin
                if (rx_fire_c) begin
                    len_lo_d = rx_tdata_i;
                    state_d  = LENHI;
                end
            end
            LENHI: begin
                if (rx_fire_c) begin
                    remaining_d = payload_c;
                    asm_clear_c = 1'b1;
                    if (len_full_c < LEN_W'(HEADER_LEN)) begin
                        err_d   = 1'b1;
                        state_d = OPC;
                    end else if (opcode_q == OP_ECHO) begin
                        state_d = (payload_c == '0) ? OPC : ECHO;
                    end else if (arith_op_c && arith_len_ok_c) begin
                        acc_d   = (opcode_q == OP_ADD32) ? '0 : OPERAND_WIDTH_P'(1);
                        state_d = ACC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = (payload_c == '0) ? OPC : DRAIN;
                    end
                end
            end
            ECHO: begin
                if (rx_fire_c) begin
                    tx_data_d   = rx_tdata_i;
                    tx_valid_d  = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (last_byte_c) state_d = OPC;
                end
            end
            ACC: begin
                if (rx_fire_c) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (word_valid_c) acc_d = result_c;
                    if (last_byte_c) begin
                        tx_data_d  = result_c[DATA_WIDTH_P-1:0];
                        tx_valid_d = 1'b1;
                        idx_d      = '0;
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                if (tx_fire_c) begin
                    if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
                        state_d = OPC;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        tx_data_d  = acc_q[2*DATA_WIDTH_P-1:DATA_WIDTH_P];
                        tx_valid_d = 1'b1;
                        acc_d      = acc_q >> DATA_WIDTH_P;
                    end
                end
            end
            DRAIN: begin
                if (rx_fire_c) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (last_byte_c) state_d = OPC;
                end
            end
            default: state_d = OPC;
        endcase
    end

endmodule

// File: tb/tb_alu_packet_responder.sv
// Directed bench for alu_packet_responder: add, wrap, echo with backpressure,
// error recovery, multiply (ALU_MUL32_EN aware), back-to-back and reset mid-packet.
module tb_alu_packet_responder;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_tready;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       busy;
    logic       err;

    bq_t txq;
    int  err_cnt  = 0;
    int  n_cmp    = 0;
    int  n_bad    = 0;
    bit  bp_en    = 1'b0;

    alu_packet_responder dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tdata_i (rx_tdata),
        .rx_tvalid_i(rx_tvalid),
        .rx_tready_o(rx_tready),
        .tx_tdata_o (tx_tdata),
        .tx_tvalid_o(tx_tvalid),
        .tx_tready_i(tx_tready),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Record tx handshakes and err pulses mid-cycle, where inputs and outputs are stable.
    always @(negedge clk) begin
        if (tx_tvalid && tx_tready) txq.push_back(tx_tdata);
        if (err) err_cnt++;
    end

    // Optional tx backpressure: toggle ready every cycle.
    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            tx_tready = ~tx_tready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] tx_word(input int base);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (base + i < txq.size()) w[8*i +: 8] = txq[base + i];
        return w;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_tready) break;
            n++;
            if (n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_accept_timeout: byte %02h not accepted, rx_tready=%0b required 1", b, rx_tready);
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input bq_t pkt);
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while (txq.size() < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic start_case();
        txq.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({tx_tvalid, tx_tdata, err, busy, rx_tready} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_values: got {tv,td,err,busy,rdy}=%03h required 000",
                     {tx_tvalid, tx_tdata, err, busy, rx_tready});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, rx_tready} !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_release: got {busy,rdy}=%02b required 01", {busy, rx_tready});
        end
    endtask

    task automatic test_add();
        start_case();
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
        wait_tx(4);
        n_cmp++;
        if (txq.size() != 4 || tx_word(0) !== 32'h0000_0003) begin
            n_bad++;
            $display("FAIL add_result: got %0d bytes word %08h required 4 bytes 00000003", txq.size(), tx_word(0));
        end
        n_cmp++;
        if (err_cnt != 0) begin
            n_bad++;
            $display("FAIL add_err: got %0d err pulses required 0", err_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL add_idle: got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_wrap();
        start_case();
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00});
        wait_tx(4);
        n_cmp++;
        if (txq.size() != 4 || tx_word(0) !== 32'h0000_0001) begin
            n_bad++;
            $display("FAIL wrap_result: got %0d bytes word %08h required 4 bytes 00000001", txq.size(), tx_word(0));
        end
    endtask

    task automatic test_echo_backpressure();
        start_case();
        bp_en = 1'b1;
        send_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43});
        wait_tx(3);
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        tx_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (txq.size() != 3 || tx_word(0) !== 32'h0043_4241) begin
            n_bad++;
            $display("FAIL echo_bp: got %0d bytes word %08h required 3 bytes 00434241", txq.size(), tx_word(0));
        end
        n_cmp++;
        if (err_cnt != 0) begin
            n_bad++;
            $display("FAIL echo_err: got %0d err pulses required 0", err_cnt);
        end
    endtask

    task automatic test_errors();
        start_case();
        send_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
        wait_tx(0);
        n_cmp++;
        if (err_cnt != 1 || txq.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_unknown: got err=%0d tx=%0d busy=%0b required err=1 tx=0 busy=0",
                     err_cnt, txq.size(), busy);
        end
        start_case();
        send_pkt('{8'hA0, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22});
        wait_tx(0);
        n_cmp++;
        if (err_cnt != 1 || txq.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_badlen: got err=%0d tx=%0d busy=%0b required err=1 tx=0 busy=0",
                     err_cnt, txq.size(), busy);
        end
        start_case();
        send_pkt('{8'hA0, 8'h00, 8'h02, 8'h00});
        wait_tx(0);
        n_cmp++;
        if (err_cnt != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_short: got err=%0d busy=%0b required err=1 busy=0", err_cnt, busy);
        end
        start_case();
        send_pkt('{8'hEC, 8'h00, 8'h04, 8'h00});
        wait_tx(0);
        n_cmp++;
        if (err_cnt != 0 || txq.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL echo_empty: got err=%0d tx=%0d busy=%0b required err=0 tx=0 busy=0",
                     err_cnt, txq.size(), busy);
        end
        start_case();
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00});
        wait_tx(4);
        n_cmp++;
        if (txq.size() != 4 || tx_word(0) !== 32'h0000_000C || err_cnt != 0) begin
            n_bad++;
            $display("FAIL recover_add: got %0d bytes word %08h err=%0d required 4 bytes 0000000c err=0",
                     txq.size(), tx_word(0), err_cnt);
        end
    endtask

    task automatic test_mul();
        logic [31:0] exp_word;
        int          exp_n;
        int          exp_err;
`ifdef ALU_MUL32_EN
        exp_word = 32'h0000_000F;
        exp_n    = 4;
        exp_err  = 0;
`else
        exp_word = 32'h0000_0000;
        exp_n    = 0;
        exp_err  = 1;
`endif
        start_case();
        send_pkt('{8'hB0, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00});
        wait_tx(exp_n);
        n_cmp++;
        if (txq.size() != exp_n || tx_word(0) !== exp_word || err_cnt != exp_err) begin
            n_bad++;
            $display("FAIL mul: got %0d bytes word %08h err=%0d required %0d bytes %08h err=%0d",
                     txq.size(), tx_word(0), err_cnt, exp_n, exp_word, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        start_case();
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00,
                   8'hA0, 8'h00, 8'h0C, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h40, 8'h30, 8'h20, 8'h10});
        wait_tx(8);
        n_cmp++;
        if (txq.size() != 8) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d bytes required 8", txq.size());
        end
        n_cmp++;
        if (tx_word(0) !== 32'h0000_0030) begin
            n_bad++;
            $display("FAIL b2b_first: got %08h required 00000030", tx_word(0));
        end
        n_cmp++;
        if (tx_word(4) !== 32'h1122_3344) begin
            n_bad++;
            $display("FAIL b2b_second: got %08h required 11223344", tx_word(4));
        end
    endtask

    task automatic test_reset_mid();
        start_case();
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00});
        #2;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got busy=%0b required 1", busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_tvalid, tx_tdata, err, busy, rx_tready} !== 12'h000) begin
            n_bad++;
            $display("FAIL mid_reset_values: got {tv,td,err,busy,rdy}=%03h required 000",
                     {tx_tvalid, tx_tdata, err, busy, rx_tready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_case();
        send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00});
        wait_tx(4);
        n_cmp++;
        if (txq.size() != 4 || tx_word(0) !== 32'h0000_0080 || err_cnt != 0) begin
            n_bad++;
            $display("FAIL mid_recover: got %0d bytes word %08h err=%0d required 4 bytes 00000080 err=0",
                     txq.size(), tx_word(0), err_cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rx_tdata  = 8'h00;
        rx_tvalid = 1'b0;
        tx_tready = 1'b1;
        test_reset();
        test_add();
        test_wrap();
        test_echo_backpressure();
        test_errors();
        test_mul();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
